// File: rtl/spi_master.sv
// ----------------------------------------------------------------------------
// spi_master
//  Initiator side of the SPI RAM link. Sends one command frame on SS_n/MOSI
//  (route bit cmd[1], then {cmd,wdata} MSB first) and, for cmd 11, captures
//  an RD_BITS response from MISO after RD_LATENCY idle cycles.
//
// Ports
//  clk          in   system clock (also SCK), rising edge
//  reset        in   synchronous, active-high
//  start        in   frame request, accepted only while idle
//  cmd[1:0]     in   00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//  wdata[7:0]   in   address/data byte
//  busy         out  high outside IDLE
//  done         out  one-cycle pulse at frame completion
//  rdata        out  last captured read byte
//  rdata_valid  out  one-cycle pulse with done for cmd-11 frames
//  SS_n         out  active-low slave select
//  MOSI         out  serial data to slave
//  MISO         in   serial data from slave
// ----------------------------------------------------------------------------
module spi_master #(
   parameter int unsigned FRAME_BITS = 10,
   parameter int unsigned RD_BITS    = 8,
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned IDLE_GAP   = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         cmd,
   input  logic [7:0]         wdata,
   output logic               busy,
   output logic               done,
   output logic [RD_BITS-1:0] rdata,
   output logic               rdata_valid,
   output logic               SS_n,
   output logic               MOSI,
   input  logic               MISO
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEND = 3'd1,
      WAIT = 3'd2,
      RECV = 3'd3,
      GAP  = 3'd4
   } state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [FRAME_BITS-1:0] shift, shift_nxt;
   logic                  rd_frame, rd_frame_nxt;
   logic [RD_BITS-1:0]    rx, rx_nxt;
   logic [RD_BITS-1:0]    rdata_nxt;
   logic                  busy_nxt, done_nxt, rdata_valid_nxt, ss_n_nxt, mosi_nxt;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         shift       <= '0;
         rd_frame    <= 1'b0;
         rx          <= '0;
         rdata       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         rdata_valid <= 1'b0;
         SS_n        <= 1'b1;
         MOSI        <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         shift       <= shift_nxt;
         rd_frame    <= rd_frame_nxt;
         rx          <= rx_nxt;
         rdata       <= rdata_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         rdata_valid <= rdata_valid_nxt;
         SS_n        <= ss_n_nxt;
         MOSI        <= mosi_nxt;
      end
   end

   // Next state; outputs are computed one cycle ahead so they leave flops
   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      shift_nxt       = shift;
      rd_frame_nxt    = rd_frame;
      rx_nxt          = rx;
      rdata_nxt       = rdata;
      done_nxt        = 1'b0;
      rdata_valid_nxt = 1'b0;
      ss_n_nxt        = 1'b1;
      mosi_nxt        = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt    = SEND;
               cnt_nxt      = '0;
               shift_nxt    = FRAME_BITS'({cmd, wdata});
               rd_frame_nxt = (cmd == 2'b11);
               ss_n_nxt     = 1'b0;
               mosi_nxt     = cmd[1];
            end
         end

         SEND: begin
            ss_n_nxt = 1'b0;
            if (cnt == CNT_W'(FRAME_BITS)) begin
               cnt_nxt = '0;
               if (!rd_frame) begin
                  state_nxt = GAP;
                  ss_n_nxt  = 1'b1;
                  done_nxt  = 1'b1;
               end else if (RD_LATENCY == 0) begin
                  state_nxt = RECV;
               end else begin
                  state_nxt = WAIT;
               end
            end else begin
               // cnt counts bits already on the wire; route bit is bit 0
               cnt_nxt   = cnt + CNT_W'(1);
               mosi_nxt  = shift[FRAME_BITS-1];
               shift_nxt = shift << 1;
            end
         end

         WAIT: begin
            ss_n_nxt = 1'b0;
            if (cnt == CNT_W'(RD_LATENCY - 1)) begin
               state_nxt = RECV;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         RECV: begin
            ss_n_nxt = 1'b0;
            rx_nxt   = {rx[RD_BITS-2:0], MISO};
            if (cnt == CNT_W'(RD_BITS - 1)) begin
               state_nxt       = GAP;
               cnt_nxt         = '0;
               ss_n_nxt        = 1'b1;
               done_nxt        = 1'b1;
               rdata_valid_nxt = 1'b1;
               rdata_nxt       = rx_nxt;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         GAP: begin
            if (cnt == CNT_W'(IDLE_GAP - 1)) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_spi_master.sv
// ----------------------------------------------------------------------------
// tb_spi_master
//  Bench for spi_master. Two instances: dut_a (RD_LATENCY=2) and dut_b
//  (RD_LATENCY=0). Expected waveforms are computed per cycle offset from the
//  accept edge using the frame timing rules.
// ----------------------------------------------------------------------------
module tb_spi_master;

   localparam int unsigned IDLE_GAP = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_a, start_b;
   logic [1:0] cmd;
   logic [7:0] wdata;
   logic       miso;

   logic       busy_a, done_a, rv_a, ss_n_a, mosi_a;
   logic [7:0] rdata_a;
   logic       busy_b, done_b, rv_b, ss_n_b, mosi_b;
   logic [7:0] rdata_b;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] model_rdata [2];

   always #5 clk = ~clk;

   spi_master #(.FRAME_BITS(10), .RD_BITS(8), .RD_LATENCY(2), .IDLE_GAP(IDLE_GAP)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .cmd(cmd), .wdata(wdata),
      .busy(busy_a), .done(done_a), .rdata(rdata_a), .rdata_valid(rv_a),
      .SS_n(ss_n_a), .MOSI(mosi_a), .MISO(miso)
   );

   spi_master #(.FRAME_BITS(10), .RD_BITS(8), .RD_LATENCY(0), .IDLE_GAP(IDLE_GAP)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .cmd(cmd), .wdata(wdata),
      .busy(busy_b), .done(done_b), .rdata(rdata_b), .rdata_valid(rv_b),
      .SS_n(ss_n_b), .MOSI(mosi_b), .MISO(miso)
   );

   // {busy, SS_n, MOSI, done, rdata_valid}
   function automatic logic [4:0] obs(input bit sel);
      return sel ? {busy_b, ss_n_b, mosi_b, done_b, rv_b}
                 : {busy_a, ss_n_a, mosi_a, done_a, rv_a};
   endfunction

   function automatic logic [7:0] obs_rdata(input bit sel);
      return sel ? rdata_b : rdata_a;
   endfunction

   task automatic set_start(input bit sel, input logic v);
      if (sel) start_b = v; else start_a = v;
   endtask

   // One full frame plus the following idle cycle, checked every cycle
   task automatic run_frame(input bit sel, input logic [1:0] c, input logic [7:0] w,
                            input logic [7:0] mb, input string name);
      int lat = sel ? 0 : 2;
      int span = (c == 2'b11) ? 19 + lat : 11;
      logic [9:0] word = {c, w};
      logic [7:0] old_rd = model_rdata[sel];
      logic [4:0] exp_o;
      logic [7:0] exp_rd;
      logic       e_mosi;
      @(negedge clk);
      set_start(sel, 1'b1);
      cmd   = c;
      wdata = w;
      for (int k = 1; k <= span + IDLE_GAP + 1; k++) begin
         @(negedge clk);
         if (k == 1) begin
            set_start(sel, 1'b0);
            cmd   = 2'($urandom);
            wdata = 8'($urandom);
         end
         if (c == 2'b11 && k >= 12 + lat && k <= 19 + lat)
            miso = mb[7 - (k - 12 - lat)];
         else
            miso = 1'($urandom);
         if (k == 1)       e_mosi = c[1];
         else if (k <= 11) e_mosi = word[11 - k];
         else              e_mosi = 1'b0;
         exp_o = {(k <= span + int'(IDLE_GAP)), !(k <= span), e_mosi,
                  (k == span + 1), (k == span + 1) && (c == 2'b11)};
         exp_rd = (c == 2'b11 && k >= span + 1) ? mb : old_rd;
         vectors++;
         if (obs(sel) !== exp_o || obs_rdata(sel) !== exp_rd) begin
            miscompares++;
            $display("FAIL %s k=%0d {busy,ss_n,mosi,done,rv}=%b rdata=%h expected %b %h",
                     name, k, obs(sel), obs_rdata(sel), exp_o, exp_rd);
         end
      end
      if (c == 2'b11) model_rdata[sel] = mb;
   endtask

   task automatic test_reset;
      reset = 1'b1; start_a = 1'b1; start_b = 1'b1;
      cmd = 2'b11; wdata = 8'hFF; miso = 1'b1;
      repeat (3) @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      model_rdata[0] = 8'h00; model_rdata[1] = 8'h00;
      for (int s = 0; s < 2; s++) begin
         vectors++;
         if (obs(s[0]) !== 5'b01000 || obs_rdata(s[0]) !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_values dut%0d got %b %h expected 01000 00",
                     s, obs(s[0]), obs_rdata(s[0]));
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_write_frame;
      run_frame(1'b0, 2'b00, 8'h3C, 8'h00, "wr_addr_3C");
   endtask

   task automatic test_read_frame;
      run_frame(1'b0, 2'b11, 8'h00, 8'hA5, "rd_data_A5");
   endtask

   // start held for HOLD edges; accepts land every 11+1+IDLE_GAP edges
   task automatic test_back_to_back;
      localparam int HOLD = 20;
      int frames = 0, low_run = 0, high_run = 0, min_high = 1000, bad_low = 0;
      bit seen_low = 0;
      int exp_frames = (HOLD + 12 + int'(IDLE_GAP) - 1) / (12 + int'(IDLE_GAP));
      @(negedge clk);
      start_a = 1'b1; cmd = 2'b01; wdata = 8'($urandom);
      for (int n = 1; n <= HOLD + 30; n++) begin
         @(negedge clk);
         if (n == HOLD) start_a = 1'b0;
         if (done_a) frames++;
         if (!ss_n_a) begin
            if (seen_low && high_run > 0 && high_run < min_high) min_high = high_run;
            low_run++; high_run = 0; seen_low = 1;
         end else begin
            if (low_run != 0 && low_run != 11) bad_low++;
            low_run = 0;
            if (seen_low) high_run++;
         end
      end
      vectors++;
      if (frames !== exp_frames || bad_low !== 0 || min_high < int'(IDLE_GAP)) begin
         miscompares++;
         $display("FAIL back_to_back frames=%0d bad_low=%0d min_high=%0d expected %0d 0 >=%0d",
                  frames, bad_low, min_high, exp_frames, IDLE_GAP);
      end
   endtask

   task automatic test_reset_mid_frame;
      int stray = 0;
      @(negedge clk);
      start_a = 1'b1; cmd = 2'b10; wdata = 8'($urandom);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) start_a = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_rdata[0] = 8'h00; model_rdata[1] = 8'h00;
      vectors++;
      if (obs(1'b0) !== 5'b01000) begin
         miscompares++;
         $display("FAIL mid_frame_reset got %b expected 01000", obs(1'b0));
      end
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (done_a || rv_a || !ss_n_a || busy_a) stray++;
      end
      vectors++;
      if (stray !== 0) begin
         miscompares++;
         $display("FAIL aborted_frame_quiet stray=%0d expected 0", stray);
      end
      // reset and start together: start is dropped
      reset = 1'b1; start_a = 1'b1; cmd = 2'b01;
      @(negedge clk);
      reset = 1'b0; start_a = 1'b0;
      @(negedge clk);
      vectors++;
      if (obs(1'b0) !== 5'b01000) begin
         miscompares++;
         $display("FAIL reset_beats_start got %b expected 01000", obs(1'b0));
      end
      run_frame(1'b0, 2'b10, 8'($urandom), 8'h00, "clean_after_reset");
   endtask

   task automatic test_rdata_hold;
      run_frame(1'b0, 2'b11, 8'($urandom), 8'hFF, "rd_stuck_one");
      run_frame(1'b0, 2'b01, 8'($urandom), 8'h00, "wr_after_rd");
      vectors++;
      if (rdata_a !== 8'hFF) begin
         miscompares++;
         $display("FAIL rdata_hold got %h expected ff", rdata_a);
      end
   endtask

   task automatic test_zero_latency;
      run_frame(1'b1, 2'b11, 8'($urandom), 8'($urandom), "lat0_rd");
      run_frame(1'b1, 2'b00, 8'($urandom), 8'h00, "lat0_wr");
   endtask

   task automatic test_random;
      for (int i = 0; i < 16; i++)
         run_frame(1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), "random");
   endtask

   initial begin
      test_reset();
      test_write_frame();
      test_read_frame();
      test_back_to_back();
      test_reset_mid_frame();
      test_rdata_hold();
      test_zero_latency();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
